// File: rtl/box_filter_sched.sv
// box_filter_sched: round-robin scheduler sharing one box-filter running-sum/divide datapath across NUM_CH streams
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        synchronous reset, active-high
//   in_valid   per-channel sample valid
//   in_data    per-channel 32-bit unsigned samples, channel i at [32*i +: 32]
//   in_ready   one-hot grant; sample taken when in_valid[i] & in_ready[i]
//   ch_clear   zero channel i window/sum/ptr/fill on next edge (wins over a sample)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   window sum / FILTER_SIZE (truncating)
//   out_ch     channel that produced out_data
//   out_warm   window of out_ch has held >= FILTER_SIZE samples
module box_filter_sched #(
   parameter int NUM_CH      = 3,
   parameter int FILTER_SIZE = 4,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1,
   localparam int FW = $clog2(FILTER_SIZE + 1),
   localparam int SW = 32 + $clog2(FILTER_SIZE) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    in_valid,
   input  logic [NUM_CH*32-1:0] in_data,
   output logic [NUM_CH-1:0]    in_ready,
   input  logic [NUM_CH-1:0]    ch_clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [CW-1:0]        out_ch,
   output logic                 out_warm
);
   logic [31:0]   win [NUM_CH][FILTER_SIZE];
   logic [PW-1:0] ptr [NUM_CH];
   logic [FW-1:0] fill [NUM_CH];
   logic [SW-1:0] sum [NUM_CH];
   logic [31:0]   din [NUM_CH];
   logic [CW-1:0] rr;
   logic [CW-1:0] gnt_ch;
   logic          gnt_any;
   logic          can_issue;
   logic [NUM_CH-1:0] eligible;
   logic [31:0]   x;
   logic [31:0]   old;
   logic [SW-1:0] new_sum;
   logic [FW-1:0] new_fill;
   logic [PW-1:0] new_ptr;

   assign eligible  = in_valid & ~ch_clear;
   assign can_issue = ~out_valid | out_ready;
   assign in_ready  = gnt_any ? (NUM_CH'(1) << gnt_ch) : '0;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) din[i] = in_data[32*i +: 32];
   end

   // search starts one past the last winner so every requester is served in turn
   always_comb begin
      gnt_any = 1'b0;
      gnt_ch  = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!gnt_any && can_issue && eligible[(int'(rr) + k) % NUM_CH]) begin
            gnt_any = 1'b1;
            gnt_ch  = CW'((int'(rr) + k) % NUM_CH);
         end
      end
   end

   // the sample leaving the window is the one about to be overwritten at ptr
   always_comb begin
      x        = din[gnt_ch];
      old      = win[gnt_ch][ptr[gnt_ch]];
      new_sum  = sum[gnt_ch] - SW'(old) + SW'(x);
      new_fill = (fill[gnt_ch] == FW'(FILTER_SIZE)) ? fill[gnt_ch] : fill[gnt_ch] + FW'(1);
      new_ptr  = (ptr[gnt_ch] == PW'(FILTER_SIZE - 1)) ? '0 : ptr[gnt_ch] + PW'(1);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst || ch_clear[i]) begin
            for (int j = 0; j < FILTER_SIZE; j++) win[i][j] <= '0;
            ptr[i]  <= '0;
            fill[i] <= '0;
            sum[i]  <= '0;
         end else if (gnt_any && gnt_ch == CW'(i)) begin
            win[i][ptr[i]] <= x;
            ptr[i]  <= new_ptr;
            fill[i] <= new_fill;
            sum[i]  <= new_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr        <= CW'(NUM_CH - 1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_warm  <= 1'b0;
      end else if (gnt_any) begin
         rr        <= gnt_ch;
         out_valid <= 1'b1;
         out_data  <= 32'(new_sum / SW'(FILTER_SIZE));
         out_ch    <= gnt_ch;
         out_warm  <= new_fill == FW'(FILTER_SIZE);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_box_filter_sched.sv
// tb_box_filter_sched: directed self-checking bench for box_filter_sched (NUM_CH=3, FILTER_SIZE=4)
module tb_box_filter_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  in_valid;
   logic [95:0] in_data;
   logic [2:0]  in_ready;
   logic [2:0]  ch_clear;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_ch;
   logic        out_warm;
   int n_tests = 0;
   int n_fail  = 0;

   box_filter_sched #(.NUM_CH(3), .FILTER_SIZE(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ch_clear(ch_clear), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_warm(out_warm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic out_is(input string tag, input logic [31:0] d, input logic [1:0] c, input logic w);
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " data"}, out_data, d);
      check({tag, " ch"}, 32'(out_ch), 32'(c));
      check({tag, " warm"}, 32'(out_warm), 32'(w));
   endtask

   logic [31:0] s2_in [5]   = '{4, 8, 12, 16, 20};
   logic [31:0] s2_out [5]  = '{1, 3, 6, 10, 14};
   logic        s2_warm [5] = '{0, 0, 0, 1, 1};
   logic [2:0]  s3_gnt [5]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
   logic [1:0]  s3_ch [5]   = '{0, 1, 2, 0, 1};
   logic [31:0] s3_out [5]  = '{1, 2, 3, 2, 4};

   initial begin
      rst = 1'b1; in_valid = '0; in_data = '0; ch_clear = '0; out_ready = 1'b1;
      tick; tick;
      check("rst out_valid", 32'(out_valid), 0);
      check("rst in_ready", 32'(in_ready), 0);
      check("rst out_data", out_data, 0);
      check("rst out_ch", 32'(out_ch), 0);
      check("rst out_warm", 32'(out_warm), 0);

      rst = 1'b0; in_valid = 3'b001;
      for (int i = 0; i < 5; i++) begin
         in_data = {64'd0, s2_in[i]};
         #1 check("s2 in_ready", 32'(in_ready), 32'b001);
         tick;
         out_is("s2", s2_out[i], 2'd0, s2_warm[i]);
      end

      rst = 1'b1; in_valid = '0; tick;
      rst = 1'b0; in_valid = 3'b111; in_data = {32'd12, 32'd8, 32'd4};
      for (int i = 0; i < 5; i++) begin
         #1 check("rr in_ready", 32'(in_ready), 32'(s3_gnt[i]));
         tick;
         out_is("rr", s3_out[i], s3_ch[i], 1'b0);
      end

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("hold in_ready", 32'(in_ready), 0);
         tick;
         out_is("hold", 32'd4, 2'd1, 1'b0);
      end
      out_ready = 1'b1;
      #1 check("release in_ready", 32'(in_ready), 32'b100);
      tick;
      out_is("release", 32'd6, 2'd2, 1'b0);
      in_valid = '0; tick;
      check("pop out_valid", 32'(out_valid), 0);

      in_valid = 3'b010; in_data = {32'd0, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 4; i++) tick;
      out_is("max", 32'hFFFF_FFFF, 2'd1, 1'b1);
      ch_clear = 3'b010;
      #1 check("clear in_ready", 32'(in_ready), 0);
      tick;
      check("clear out_valid", 32'(out_valid), 0);
      ch_clear = '0; in_data = {32'd0, 32'd8, 32'd0};
      tick;
      out_is("after clear", 32'd2, 2'd1, 1'b0);

      in_valid = 3'b001; in_data = {32'd0, 32'd0, 32'd100}; out_ready = 1'b0;
      tick;
      check("stall out_valid", 32'(out_valid), 1);
      rst = 1'b1; tick;
      check("mid rst out_valid", 32'(out_valid), 0);
      check("mid rst out_data", out_data, 0);
      rst = 1'b0; out_ready = 1'b1; in_valid = 3'b011; in_data = {32'd0, 32'd8, 32'd4};
      tick;
      out_is("restart ch0", 32'd1, 2'd0, 1'b0);
      tick;
      out_is("restart ch1", 32'd2, 2'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
